// File: rtl/bus_initiator_pkg.sv
// Shared constants for the single-outstanding bus initiator: FSM encoding,
// timeout counter width and the default timeout.
package bus_initiator_pkg;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StReq      = 2'd1;
  localparam logic [1:0] StWaitResp = 2'd2;
  localparam logic [1:0] StResp     = 2'd3;

  localparam int unsigned CntWidth       = 8;
  localparam int unsigned TimeoutDefault = 255;

endpackage

// File: rtl/bus_initiator.sv
// Command-to-bus initiator: accepts one command, drives a registered bus request,
// collects the ack/read response (or times out) and presents a single completion.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_be,
  input  logic [31:0] cmd_wdata,

  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_resp,
  input  logic [31:0] bus_rdata,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [31:0]         bus_addr_q, bus_addr_d;
  logic [3:0]          bus_be_q, bus_be_d;
  logic [31:0]         bus_wdata_q, bus_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d     = StReq;
          cnt_d       = '0;
          bus_we_d    = cmd_we;
          bus_addr_d  = cmd_addr;
          bus_be_d    = cmd_be;
          bus_wdata_d = cmd_wdata;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      StReq: begin
        // Completion is checked before the timeout so it wins a same-cycle tie.
        if (bus_ack && (bus_we_q || bus_resp)) begin
          state_d     = StResp;
          rsp_rdata_d = bus_we_q ? 32'h0 : bus_rdata;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == TimeoutLast) begin
          state_d     = StResp;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (bus_ack) state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        if (bus_resp) begin
          state_d     = StResp;
          rsp_rdata_d = bus_rdata;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == TimeoutLast) begin
          state_d     = StResp;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    bus_req_d   = (state_d == StReq);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: directed scenarios plus randomized transactions checked
// against a transaction-level timing/result model.
module tb_bus_initiator;

  localparam int unsigned T = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        bus_req, bus_we, bus_ack, bus_resp;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_err    = 0;

  bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_be    (cmd_be),
    .cmd_wdata (cmd_wdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_resp  (bus_resp),
    .bus_rdata (bus_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_be    = be;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_be    = 4'($urandom);
    cmd_wdata = $urandom;
  endtask

  // a: bus cycle (0 = first bus_req cycle) carrying bus_ack; r: read response delay
  // after the ack cycle; hold: cycles rsp_ready stays low once the completion shows.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int a, input int r, input int hold);
    int          c, done, reqlast;
    bit          tmo;
    logic [31:0] exp_rd;
    c       = we ? a : a + r;
    tmo     = (c > int'(T) - 1);
    reqlast = (a < int'(T) - 1) ? a : int'(T) - 1;
    done    = tmo ? int'(T) : c + 1;
    exp_rd  = (tmo || we) ? 32'h0 : rd;

    issue(we, addr, be, wd);
    for (int k = 0; k <= done; k++) begin
      chk("bus_req", {31'b0, bus_req}, (k <= reqlast) ? 32'd1 : 32'd0);
      chk("rsp_valid", {31'b0, rsp_valid}, (k == done) ? 32'd1 : 32'd0);
      chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
      if (k <= reqlast) begin
        chk("bus_we", {31'b0, bus_we}, {31'b0, we});
        chk("bus_addr", bus_addr, addr);
        chk("bus_be", {28'b0, bus_be}, {28'b0, be});
        chk("bus_wdata", bus_wdata, wd);
      end
      if (k < done) begin
        bus_ack   = (k == a);
        bus_resp  = !we && (k == a + r);
        bus_rdata = bus_resp ? rd : $urandom;
        tick();
      end
    end
    bus_ack  = 1'b0;
    bus_resp = 1'b0;
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, tmo});

    // Responder noise while the completion is held must not disturb it.
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      bus_ack   = 1'($urandom);
      bus_resp  = 1'($urandom);
      bus_rdata = $urandom;
      tick();
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", {31'b0, rsp_err}, {31'b0, tmo});
      chk("hold_bus_req", {31'b0, bus_req}, 32'd0);
    end
    rsp_ready = 1'b1;
    bus_ack   = 1'b0;
    bus_resp  = 1'b0;
    tick();
    rsp_ready = 1'b0;
    chk("post_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst_i     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_be    = '0;
    cmd_wdata = '0;
    bus_ack   = 1'b0;
    bus_resp  = 1'b0;
    bus_rdata = '0;
    rsp_ready = 1'b0;

    #12;
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    chk("rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Write acked on first request cycle.
    run_txn(1'b1, 32'h0000_0085, 4'hF, 32'h1, 32'h0, 0, 0, 0);
    // Read, response one cycle after ack.
    run_txn(1'b0, 32'h0000_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
    // Read, ack and response together.
    run_txn(1'b0, 32'h0000_0010, 4'h3, 32'h0, 32'h1234_5678, 0, 0, 0);
    // No ack at all: timeout; late responses land in the hold phase.
    run_txn(1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'hAAAA_5555, 99, 0, 3);
    // Completion on the last allowed cycle beats the timeout.
    run_txn(1'b0, 32'h0000_0024, 4'hF, 32'h0, 32'hCAFE_F00D, 1, 2, 0);
    // Read acked but response too late: timeout from WAIT_RESP.
    run_txn(1'b0, 32'h0000_0028, 4'hF, 32'h0, 32'h0BAD_0BAD, 1, 3, 0);
    // Completion held with rsp_ready low for five cycles.
    run_txn(1'b1, 32'h0000_0030, 4'hC, 32'h5A5A_A5A5, 32'h0, 2, 0, 5);

    // Reset while waiting for a read response.
    issue(1'b0, 32'h0000_0040, 4'hF, 32'h0);
    chk("abort_req", {31'b0, bus_req}, 32'd1);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("abort_wait_req", {31'b0, bus_req}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("abort_bus_req", {31'b0, bus_req}, 32'd0);
    chk("abort_bus_addr", bus_addr, 32'd0);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    rst_i     = 1'b1;
    bus_ack   = 1'b1;
    bus_resp  = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack  = 1'b0;
    bus_resp = 1'b0;
    chk("stray_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("stray_rsp_rdata", rsp_rdata, 32'd0);
    chk("stray_bus_req", {31'b0, bus_req}, 32'd0);
    run_txn(1'b0, 32'h0000_0044, 4'hF, 32'h0, 32'h7777_1111, 0, 1, 1);

    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
